eof_frame_end_checker: RTL and testbench
========================================

Name: eof_frame_end_checker

Overview:
- Parametrised successor to the CAN decoder's EOF error block.
- Checks the recessive End-of-Frame field and, optionally, the Intermission field that follows it, one bit per sample-point strobe.
- Flags form errors and overload conditions, reports field completion, and reports the end-of-intermission SOF detection.
- Sits after the CRC/ACK decoding stages and feeds the error-handling and overload-frame logic.

Parameters:
- EOF_LEN, 7: number of EOF bits checked (legal 2..15).
- INT_LEN, 3: number of Intermission bits (legal 2..7; used only with INTERMISSION_CHECK_EN).
- LAST_BIT_OVLD, 1: 1 = dominant on the last EOF bit raises an overload (receiver rule); 0 = it raises a form error (transmitter rule).
- CNT_W, 4: bit-counter width; must satisfy 2**CNT_W > max(EOF_LEN, INT_LEN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- SP  in  1  sample-point strobe, one clk wide, once per CAN bit.
- RX  in  1  synchronised bus level (0 = dominant, 1 = recessive).
- EOF_Flag  in  1  one-clk pulse: the next SP is the first EOF bit.
- EOF_Error  out  1  form error detected; sticky.
- Overload_Flag  out  1  overload condition detected; sticky.
- EOF_Done  out  1  one-clk pulse when the field check completes without error.
- SOF_Detect  out  1  one-clk pulse when a dominant bit is seen on the last Intermission bit.
- Busy  out  1  high in EOF or INTERM state.
- Bit_Cnt  out  CNT_W  index of the next bit to be sampled within the current field.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; all outputs 0; Bit_Cnt = 0.
- All outputs are registered. Each output updates on the clk edge that samples SP = 1, so it is visible one cycle after the SP strobe.

States: IDLE, EOF, INTERM, ERR, OVLD.

- IDLE: SP is ignored. EOF_Flag → EOF, Bit_Cnt = 0, and the sticky flags are cleared.
- EOF, on SP:
  - RX = 1 and Bit_Cnt < EOF_LEN-1: Bit_Cnt + 1.
  - RX = 1 and Bit_Cnt = EOF_LEN-1: go to INTERM with Bit_Cnt = 0 (with the macro), or pulse EOF_Done and go to IDLE (without it).
  - RX = 0 and Bit_Cnt < EOF_LEN-1: EOF_Error = 1, go to ERR.
  - RX = 0 and Bit_Cnt = EOF_LEN-1: Overload_Flag = 1 and go to OVLD if LAST_BIT_OVLD = 1; otherwise EOF_Error = 1 and go to ERR.
- INTERM, on SP:
  - RX = 1 and Bit_Cnt < INT_LEN-1: Bit_Cnt + 1.
  - RX = 1 and Bit_Cnt = INT_LEN-1: EOF_Done pulse, go to IDLE.
  - RX = 0 and Bit_Cnt < INT_LEN-1: Overload_Flag = 1, go to OVLD.
  - RX = 0 and Bit_Cnt = INT_LEN-1: EOF_Done and SOF_Detect pulse together, go to IDLE; no error.
- ERR / OVLD: hold the sticky flag and Bit_Cnt; SP is ignored. Only EOF_Flag or reset leaves these states.
- EOF_Flag in any state restarts the check: go to EOF, Bit_Cnt = 0, EOF_Error = 0, Overload_Flag = 0.
- EOF_Flag and SP in the same cycle: EOF_Flag wins and that SP is not sampled.
- SP = 0: no state or counter change.
- Bit_Cnt never exceeds max(EOF_LEN, INT_LEN) - 1; there is no wrap-around.
- Busy is a combinational decode of the registered state, so it is high from the cycle after EOF_Flag.
- Reset mid-field aborts immediately to IDLE with all outputs at 0.

Optional Feature:
- Macro INTERMISSION_CHECK_EN.
- Defined: the INTERM state, SOF_Detect and the intermission overload check are compiled in.
- Undefined:
  - INTERM is removed.
  - EOF_Done pulses after the last EOF bit.
  - SOF_Detect is tied to 0.
  - INT_LEN is unused.

Decomposition:
- Shared package can_dec_pkg holds:
  - the state enum (IDLE, EOF, INTERM, ERR, OVLD);
  - the constants CAN_DOMINANT = 0, CAN_RECESSIVE = 1, CAN_EOF_LEN = 7 and CAN_INT_LEN = 3.
- Sub-module field_bit_counter (load, enable on SP, terminal-count compare against a length input) is reused for both the EOF and INTERM counts.

Test Plan (default parameters, macro defined):
- EOF_Flag, then 7 SP with RX = 1, then 3 SP with RX = 1 → EOF_Done pulses once, one clk after the 10th SP; EOF_Error = 0; Overload_Flag = 0.
- RX = 0 on EOF bit 3 (Bit_Cnt = 3) → EOF_Error = 1 one clk after that SP; it stays 1 through 6 further SP pulses until the next EOF_Flag.
- RX = 0 on EOF bit 6 → Overload_Flag = 1, EOF_Error = 0. With LAST_BIT_OVLD = 0: EOF_Error = 1 and Overload_Flag = 0.
- RX = 0 on EOF bit 0 → EOF_Error = 1, Bit_Cnt frozen at 0. Then EOF_Flag and a clean field → EOF_Error clears and EOF_Done pulses.
- Clean EOF, intermission bit 1 dominant → Overload_Flag = 1. Separately, intermission bit 2 dominant → SOF_Detect = 1 and EOF_Done = 1 on the same clk, with no error.
- Reset asserted mid-EOF at Bit_Cnt = 4 → all outputs 0 immediately. EOF_Flag coincident with SP → Bit_Cnt = 0 and that SP is not sampled.

Source files
------------

// File: rtl/can_dec_pkg.sv
// ============================================================================
// Module : can_dec_pkg
// Brief  : Shared CAN decoder types and constants (frame-end state, bus levels,
//          default EOF / Intermission field lengths).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package can_dec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EOF    = 3'd1,
        INTERM = 3'd2,
        ERR    = 3'd3,
        OVLD   = 3'd4
    } eof_state_e;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam int   CAN_EOF_LEN   = 7;
    localparam int   CAN_INT_LEN   = 3;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/field_bit_counter.sv
// ============================================================================
// Module : field_bit_counter
// Brief  : Bit index counter for a fixed-length CAN field; saturates at the
//          terminal count (len_i - 1) and flags it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module field_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == (len_i - 1'b1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/eof_frame_end_checker.sv
// ============================================================================
// Module : eof_frame_end_checker
// Brief  : Checks the recessive EOF field (and, with INTERMISSION_CHECK_EN,
//          the Intermission field) one bit per sample point strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eof_frame_end_checker
    import can_dec_pkg::*;
#(
    parameter int EOF_LEN       = CAN_EOF_LEN,
    parameter int INT_LEN       = CAN_INT_LEN,
    parameter int LAST_BIT_OVLD = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SP,
    input  logic             RX,
    input  logic             EOF_Flag,
    output logic             EOF_Error,
    output logic             Overload_Flag,
    output logic             EOF_Done,
    output logic             SOF_Detect,
    output logic             Busy,
    output logic [CNT_W-1:0] Bit_Cnt
);

    localparam int               c_max_len = max_len(EOF_LEN, INT_LEN);
    localparam logic [CNT_W-1:0] c_eof_len = CNT_W'(EOF_LEN);

    generate
        if ((2 ** CNT_W) <= c_max_len) begin : g_bad_cnt_w
            $error("CNT_W too narrow for the configured field lengths");
        end
    endgenerate

    eof_state_e state_q, state_d;
    logic       err_q, err_d;
    logic       ovld_q, ovld_d;
    logic       done_q, done_d;
    logic       w_load;
    logic       w_adv;
    logic       w_last;
    logic [CNT_W-1:0] w_len;

`ifdef INTERMISSION_CHECK_EN
    localparam logic [CNT_W-1:0] c_int_len = CNT_W'(INT_LEN);
    logic       sof_q, sof_d;

    assign w_len      = (state_q == INTERM) ? c_int_len : c_eof_len;
    assign SOF_Detect = sof_q;
`else
    assign w_len      = c_eof_len;
    assign SOF_Detect = 1'b0;
`endif

    field_bit_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_load),
        .en_i   (w_adv),
        .len_i  (w_len),
        .cnt_o  (Bit_Cnt),
        .last_o (w_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ovld_d  = ovld_q;
        done_d  = 1'b0;
`ifdef INTERMISSION_CHECK_EN
        sof_d   = 1'b0;
`endif
        w_load  = 1'b0;
        w_adv   = 1'b0;

        // A restart request outranks a coincident strobe: that bit is dropped.
        if (EOF_Flag) begin
            state_d = EOF;
            err_d   = 1'b0;
            ovld_d  = 1'b0;
            w_load  = 1'b1;
        end else if (SP) begin
            case (state_q)
                EOF: begin
                    if (RX == CAN_RECESSIVE) begin
                        if (!w_last) begin
                            w_adv = 1'b1;
                        end else begin
`ifdef INTERMISSION_CHECK_EN
                            state_d = INTERM;
                            w_load  = 1'b1;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end else if (w_last && (LAST_BIT_OVLD != 0)) begin
                        state_d = OVLD;
                        ovld_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
`ifdef INTERMISSION_CHECK_EN
                INTERM: begin
                    if (RX == CAN_RECESSIVE) begin
                        if (!w_last) begin
                            w_adv = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (!w_last) begin
                        state_d = OVLD;
                        ovld_d  = 1'b1;
                    end else begin
                        // Dominant on the final intermission bit is a new SOF.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        sof_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            ovld_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef INTERMISSION_CHECK_EN
            sof_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ovld_q  <= ovld_d;
            done_q  <= done_d;
`ifdef INTERMISSION_CHECK_EN
            sof_q   <= sof_d;
`endif
        end
    end

    assign EOF_Error     = err_q;
    assign Overload_Flag = ovld_q;
    assign EOF_Done      = done_q;
    assign Busy          = (state_q == EOF) || (state_q == INTERM);

endmodule

`default_nettype wire

// File: tb/tb_eof_frame_end_checker.sv
// ============================================================================
// Module : tb_eof_frame_end_checker
// Brief  : Self-checking bench: receiver- and transmitter-rule instances driven
//          in parallel and compared each cycle against a bit-position model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eof_frame_end_checker;

    localparam int EOF_LEN = 7;
    localparam int INT_LEN = 3;
    localparam int CNT_W   = 4;
`ifdef INTERMISSION_CHECK_EN
    localparam bit HAS_INT = 1'b1;
`else
    localparam bit HAS_INT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic SP = 1'b0;
    logic RX = 1'b1;
    logic EOF_Flag = 1'b0;

    logic             r_err, r_ovld, r_done, r_sof, r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             t_err, t_ovld, t_done, t_sof, t_busy;
    logic [CNT_W-1:0] t_cnt;

    always #5 clk = ~clk;

    eof_frame_end_checker #(
        .EOF_LEN(EOF_LEN), .INT_LEN(INT_LEN), .LAST_BIT_OVLD(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .SP(SP), .RX(RX), .EOF_Flag(EOF_Flag),
        .EOF_Error(r_err), .Overload_Flag(r_ovld), .EOF_Done(r_done),
        .SOF_Detect(r_sof), .Busy(r_busy), .Bit_Cnt(r_cnt)
    );

    eof_frame_end_checker #(
        .EOF_LEN(EOF_LEN), .INT_LEN(INT_LEN), .LAST_BIT_OVLD(0), .CNT_W(CNT_W)
    ) dut_tx (
        .clk(clk), .reset(reset), .SP(SP), .RX(RX), .EOF_Flag(EOF_Flag),
        .EOF_Error(t_err), .Overload_Flag(t_ovld), .EOF_Done(t_done),
        .SOF_Detect(t_sof), .Busy(t_busy), .Bit_Cnt(t_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a field is the sequence of sampled bits since the last EOF_Flag.
    // Position p < EOF_LEN is an EOF bit; beyond that, an Intermission bit.
    bit m_active = 0;
    int m_pos    = 0;
    int m_cnt    = 0;
    bit m_done   = 0;
    bit m_sof    = 0;
    bit m_err_r  = 0, m_ovld_r = 0;
    bit m_err_t  = 0, m_ovld_t = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_pos = 0; m_cnt = 0; m_done = 0; m_sof = 0;
            m_err_r = 0; m_ovld_r = 0; m_err_t = 0; m_ovld_t = 0;
        end else begin
            m_done = 0;
            m_sof  = 0;
            if (EOF_Flag) begin
                m_active = 1; m_pos = 0; m_cnt = 0;
                m_err_r = 0; m_ovld_r = 0; m_err_t = 0; m_ovld_t = 0;
            end else if (SP && m_active) begin
                if (m_pos < EOF_LEN) begin
                    if (RX) begin
                        if (m_pos < EOF_LEN - 1) m_cnt = m_pos + 1;
                        else if (HAS_INT)        m_cnt = 0;
                        else begin m_done = 1; m_active = 0; end
                    end else begin
                        m_active = 0;
                        if (m_pos == EOF_LEN - 1) begin
                            m_ovld_r = 1; m_err_t = 1;
                        end else begin
                            m_err_r = 1; m_err_t = 1;
                        end
                    end
                end else begin
                    int q;
                    q = m_pos - EOF_LEN;
                    m_active = 0;
                    if (q < INT_LEN - 1) begin
                        if (RX) begin m_cnt = q + 1; m_active = 1; end
                        else begin m_ovld_r = 1; m_ovld_t = 1; end
                    end else begin
                        m_done = 1;
                        m_sof  = !RX;
                    end
                end
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_err_rx",  r_err,  m_err_r);
            chk("cyc_ovld_rx", r_ovld, m_ovld_r);
            chk("cyc_err_tx",  t_err,  m_err_t);
            chk("cyc_ovld_tx", t_ovld, m_ovld_t);
            chk("cyc_done",    {r_done, t_done}, {m_done, m_done});
            chk("cyc_sof",     {r_sof, t_sof},   {m_sof, m_sof});
            chk("cyc_busy",    {r_busy, t_busy}, {m_active, m_active});
            chk("cyc_cnt_rx",  r_cnt, m_cnt);
            chk("cyc_cnt_tx",  t_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_flag();
        EOF_Flag = 1'b1; SP = 1'b0;
        tick();
        EOF_Flag = 1'b0;
    endtask

    task automatic send(input logic rx);
        SP = 1'b1; RX = rx;
        tick();
        SP = 1'b0; RX = 1'b1;
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send(1'b1);
    endtask

    initial begin
        tick(); tick();
        chk("rst_outputs", {r_err, r_ovld, r_done, r_sof, r_busy}, 5'b0);
        chk("rst_cnt", r_cnt, 0);
        reset = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Clean field
        pulse_flag();
        chk("flag_busy", r_busy, 1);
        send_ones(EOF_LEN + (HAS_INT ? INT_LEN : 0));
        chk("clean_done", {r_done, r_err, r_ovld, r_sof}, 4'b1000);
        tick();
        chk("clean_done_pulse", r_done, 0);

        // Dominant on EOF bit 3 is a sticky form error
        pulse_flag();
        send_ones(3); send(1'b0);
        chk("err3_rx", {r_err, r_ovld, r_busy}, 3'b100);
        chk("err3_cnt", r_cnt, 3);
        send_ones(6);
        chk("err3_sticky", {r_err, t_err}, 2'b11);
        chk("err3_cnt_hold", r_cnt, 3);

        // Dominant on last EOF bit: overload (rx) vs form error (tx)
        pulse_flag();
        send_ones(6); send(1'b0);
        chk("last_rx", {r_ovld, r_err}, 2'b10);
        chk("last_tx", {t_ovld, t_err}, 2'b01);

        // Dominant on bit 0, then a clean restart
        pulse_flag();
        send(1'b0);
        chk("err0", {r_err, 4'(r_cnt)}, 5'b10000);
        pulse_flag();
        chk("err0_cleared", r_err, 0);
        send_ones(EOF_LEN + (HAS_INT ? INT_LEN : 0));
        chk("err0_done", {r_done, r_err}, 2'b10);

`ifdef INTERMISSION_CHECK_EN
        pulse_flag();
        send_ones(EOF_LEN); send(1'b1); send(1'b0);
        chk("int1_ovld", {r_ovld, r_err, t_ovld, r_done}, 4'b1010);
        pulse_flag();
        send_ones(EOF_LEN); send(1'b1); send(1'b1); send(1'b0);
        chk("int2_sof", {r_sof, r_done, r_err, r_ovld}, 4'b1100);
`endif

        // Asynchronous reset mid-EOF
        pulse_flag();
        send_ones(4);
        chk("pre_rst_cnt", r_cnt, 4);
        reset = 1'b0;
        #1;
        chk("async_rst", {r_err, r_ovld, r_done, r_sof, r_busy, 4'(r_cnt)}, 9'b0);
        tick();
        reset = 1'b1;
        tick();

        // EOF_Flag coincident with SP: the strobe is dropped
        pulse_flag();
        send_ones(2);
        chk("pre_coinc_cnt", r_cnt, 2);
        EOF_Flag = 1'b1; SP = 1'b1; RX = 1'b0;
        tick();
        EOF_Flag = 1'b0; SP = 1'b0; RX = 1'b1;
        chk("coinc", {r_err, r_busy, 4'(r_cnt)}, 6'b010000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            EOF_Flag = ($urandom_range(0, 59) == 0);
            SP       = ($urandom_range(0, 2) == 0);
            RX       = ($urandom_range(0, 11) != 0);
            tick();
        end
        EOF_Flag = 1'b0; SP = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
